exp_3x3_ker_read_cont: RTL

EXP_3X3_KER_READ_CONT -- requirements
Module: exp_3x3_ker_read_cont

---
 rtl/exp_3x3_pkg.sv | 20 ++
 rtl/exp_3x3_ker_read_cont.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/exp_3x3_pkg.sv
// Shared encodings and widths for the 3x3 expand-kernel read controller.
package exp_3x3_pkg;

    localparam int OFFSET_W = 6;
    localparam int SWEEP_W  = 14;
    localparam int BANK_W   = 8;
    localparam int ADDR_W   = 7;

    localparam logic [ADDR_W-1:0] BANK2_BASE = 7'd64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BANK = 3'd1,
        WAIT_REQ  = 3'd2,
        SWEEP     = 3'd3,
        RELEASE   = 3'd4,
        DONE      = 3'd5
    } state_e;

endpackage

// File: rtl/exp_3x3_ker_read_cont.sv
// Double-banked kernel RAM read sequencer: sweeps one bank per request, releases it, ping-pongs to the other.
// Handshake: layer_N_ready_i is a level qualifying a bank; sweep_req_i is sampled only in WAIT_REQ.
module exp_3x3_ker_read_cont
    import exp_3x3_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [5:0]  rd_end_addr_i,
    input  logic [13:0] sweep_limit_i,
    input  logic [7:0]  bank_limit_i,
    input  logic        layer_1_ready_i,
    input  logic        layer_2_ready_i,
    output logic        layer_1_done_o,
    output logic        layer_2_done_o,
    input  logic        sweep_req_i,
    output logic [6:0]  exp_3x3_ram_rd_addr_o,
    output logic        exp_3x3_ram_rd_en_o,
    output logic        ker_valid_o,
    output logic        ker_last_o,
    output logic        busy_o,
    output logic        fire_done_o
);

    state_e              state_q, state_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [OFFSET_W-1:0] end_q, end_d;
    logic [SWEEP_W-1:0]  sweep_cnt_q, sweep_cnt_d;
    logic [SWEEP_W-1:0]  sweep_lim_q, sweep_lim_d;
    logic [BANK_W-1:0]   bank_cnt_q, bank_cnt_d;
    logic [BANK_W-1:0]   bank_lim_q, bank_lim_d;
    logic                bank_sel_q, bank_sel_d;

    logic                rd_en_d, last_d, last_q;
    logic [ADDR_W-1:0]   addr_d;
    logic                l1_done_d, l2_done_d, busy_d, fire_d;

    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        end_d       = end_q;
        sweep_cnt_d = sweep_cnt_q;
        sweep_lim_d = sweep_lim_q;
        bank_cnt_d  = bank_cnt_q;
        bank_lim_d  = bank_lim_q;
        bank_sel_d  = bank_sel_q;

        if (start_i) begin
            state_d     = WAIT_BANK;
            end_d       = rd_end_addr_i;
            sweep_lim_d = sweep_limit_i;
            bank_lim_d  = bank_limit_i;
            offset_d    = '0;
            sweep_cnt_d = '0;
            bank_cnt_d  = '0;
            bank_sel_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                WAIT_BANK: begin
                    if (bank_sel_q ? layer_2_ready_i : layer_1_ready_i)
                        state_d = WAIT_REQ;
                end
                WAIT_REQ: begin
                    if (sweep_req_i) begin
                        state_d  = SWEEP;
                        offset_d = '0;
                    end
                end
                SWEEP: begin
                    if (offset_q == end_q) begin
                        offset_d = '0;
                        if (sweep_cnt_q == sweep_lim_q) begin
                            sweep_cnt_d = '0;
                            state_d     = RELEASE;
                        end else begin
                            sweep_cnt_d = sweep_cnt_q + 14'd1;
                            state_d     = WAIT_REQ;
                        end
                    end else begin
                        offset_d = offset_q + 6'd1;
                    end
                end
                RELEASE: begin
                    bank_sel_d = ~bank_sel_q;
                    if (bank_cnt_q == bank_lim_q) begin
                        state_d = DONE;
                    end else begin
                        bank_cnt_d = bank_cnt_q + 8'd1;
                        state_d    = WAIT_BANK;
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from next-state values so the registered copies line up with state_q.
    always_comb begin
        rd_en_d   = (state_d == SWEEP);
        addr_d    = '0;
        if (rd_en_d)
            addr_d = (bank_sel_d ? BANK2_BASE : 7'd0) + {1'b0, offset_d};
        last_d    = rd_en_d && (offset_d == end_d);
        l1_done_d = (state_d == RELEASE) && !bank_sel_d;
        l2_done_d = (state_d == RELEASE) && bank_sel_d;
        busy_d    = (state_d != IDLE) && (state_d != DONE);
        fire_d    = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q               <= IDLE;
            offset_q              <= '0;
            end_q                 <= '0;
            sweep_cnt_q           <= '0;
            sweep_lim_q           <= '0;
            bank_cnt_q            <= '0;
            bank_lim_q            <= '0;
            bank_sel_q            <= 1'b0;
            last_q                <= 1'b0;
            exp_3x3_ram_rd_en_o   <= 1'b0;
            exp_3x3_ram_rd_addr_o <= '0;
            ker_valid_o           <= 1'b0;
            ker_last_o            <= 1'b0;
            layer_1_done_o        <= 1'b0;
            layer_2_done_o        <= 1'b0;
            busy_o                <= 1'b0;
            fire_done_o           <= 1'b0;
        end else begin
            state_q               <= state_d;
            offset_q              <= offset_d;
            end_q                 <= end_d;
            sweep_cnt_q           <= sweep_cnt_d;
            sweep_lim_q           <= sweep_lim_d;
            bank_cnt_q            <= bank_cnt_d;
            bank_lim_q            <= bank_lim_d;
            bank_sel_q            <= bank_sel_d;
            last_q                <= last_d;
            exp_3x3_ram_rd_en_o   <= rd_en_d;
            exp_3x3_ram_rd_addr_o <= addr_d;
            ker_valid_o           <= exp_3x3_ram_rd_en_o;
            ker_last_o            <= last_q;
            layer_1_done_o        <= l1_done_d;
            layer_2_done_o        <= l2_done_d;
            busy_o                <= busy_d;
            fire_done_o           <= fire_d;
        end
    end

endmodule
